// File: rtl/pe_pkg.sv
// Shared definitions for the PE chain: sequencer state encoding and default chain geometry.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    READ   = 2'd3
  } pe_state_e;

  localparam int PE_NUM_PE_DEF = 8;
  localparam int PE_LEN_W_DEF  = 10;

endpackage

// File: rtl/pe_chain_seq.sv
// Job sequencer for a linear complex-MAC PE chain: gates K input pairs in, drains the
// weight pipeline for NUM_PE-1 cycles, then hands out one accumulator index per result handshake.
module pe_chain_seq
  import pe_pkg::*;
#(
  parameter int NUM_PE = PE_NUM_PE_DEF,
  parameter int LEN_W  = PE_LEN_W_DEF,
  parameter int SEL_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             feed_gate,
  output logic             pe_en,
  output logic             pe_valid,
  output logic [SEL_W-1:0] res_sel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_last
);

  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_PE - 1);
  localparam logic [SEL_W-1:0] DRAIN_INI = SEL_W'(NUM_PE - 1);

  pe_state_e        state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] term_cnt_q;
  logic [SEL_W-1:0] drain_cnt_q;
  logic [SEL_W-1:0] res_sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      term_cnt_q  <= '0;
      drain_cnt_q <= '0;
      res_sel_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q      <= cfg_len;
            term_cnt_q <= '0;
            res_sel_q  <= '0;
            state_q    <= (cfg_len == '0) ? READ : STREAM;
          end
        end
        STREAM: begin
          if (in_valid) begin
            term_cnt_q <= term_cnt_q + LEN_W'(1);
            if (term_cnt_q == len_q - LEN_W'(1)) begin
              // A single PE has no weight pipeline to flush.
              if (NUM_PE == 1) begin
                state_q <= READ;
              end else begin
                state_q     <= DRAIN;
                drain_cnt_q <= DRAIN_INI;
              end
            end
          end
        end
        DRAIN: begin
          drain_cnt_q <= drain_cnt_q - SEL_W'(1);
          if (drain_cnt_q == SEL_W'(1)) state_q <= READ;
        end
        READ: begin
          if (res_ready) begin
            if (res_sel_q == LAST_SEL) begin
              res_sel_q <= '0;
              state_q   <= IDLE;
            end else begin
              res_sel_q <= res_sel_q + SEL_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // pe_en stays high through READ: zero terms hold the accumulators, pe_en=0 would clear them.
  assign busy      = (state_q != IDLE);
  assign pe_en     = (state_q != IDLE);
  assign in_ready  = (state_q == STREAM);
  assign feed_gate = (state_q == STREAM) && in_valid;
  assign pe_valid  = (state_q == STREAM) && in_valid;
  assign res_valid = (state_q == READ);
  assign res_sel   = res_sel_q;
  assign res_last  = (state_q == READ) && (res_sel_q == LAST_SEL);
  assign done      = res_last && res_ready;

endmodule

// File: tb/tb_pe_chain_seq.sv
// Randomized bench for pe_chain_seq with a toy 4-PE accumulator chain driven by the DUT controls.
module tb_pe_chain_seq;

  localparam int NP = 4;
  localparam int LW = 10;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          in_valid = 1'b0;
  logic          res_ready = 1'b0;
  logic          busy, done, in_ready, feed_gate, pe_en, pe_valid, res_valid, res_last;
  logic [SW-1:0] res_sel;
  logic [7:0]    din = '0, wt = '0;

  pe_chain_seq #(.NUM_PE(NP), .LEN_W(LW), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .feed_gate(feed_gate), .pe_en(pe_en),
    .pe_valid(pe_valid), .res_sel(res_sel), .res_valid(res_valid), .res_ready(res_ready),
    .res_last(res_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Toy chain: PE i sees each gated pair i edges after PE0 and weights it by (i+1).
  longint acc [NP];
  longint pipe [NP];
  longint p0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) begin
        acc[i]  <= 0;
        pipe[i] <= 0;
      end
    end else begin
      p0 = feed_gate ? longint'(din) * longint'(wt) : 0;
      for (int i = 0; i < NP; i++)
        acc[i] <= pe_en ? acc[i] + longint'(i + 1) * ((i == 0) ? p0 : pipe[i]) : 0;
      pipe[1] <= p0;
      for (int i = 2; i < NP; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Job-level reference: terms taken, cycles left before results, results handed out.
  bit     m_act;
  int     m_k, m_hs, m_wait, m_idx;
  longint m_sum;
  bit     e_strm, e_rd;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_act = 0; m_k = 0; m_hs = 0; m_wait = 0; m_idx = 0; m_sum = 0;
    end else begin
      e_strm = m_act && (m_hs < m_k);
      e_rd   = m_act && (m_hs == m_k) && (m_wait == 0);
      chk("busy", busy, m_act);
      chk("pe_en", pe_en, m_act);
      chk("in_ready", in_ready, e_strm);
      chk("feed_gate", feed_gate, e_strm && in_valid);
      chk("pe_valid", pe_valid, e_strm && in_valid);
      chk("res_valid", res_valid, e_rd);
      chk("res_last", res_last, e_rd && (m_idx == NP - 1));
      chk("done", done, e_rd && res_ready && (m_idx == NP - 1));
      if (e_rd) chk("res_sel", res_sel, m_idx);
      if (e_rd && res_ready) chk("acc_value", acc[m_idx], longint'(m_idx + 1) * m_sum);
      if (!m_act) begin
        if (start) begin
          m_act = 1; m_k = int'(cfg_len); m_hs = 0; m_wait = 0; m_idx = 0; m_sum = 0;
        end
      end else if (e_strm) begin
        if (in_valid) begin
          m_sum += longint'(din) * longint'(wt);
          m_hs++;
          if (m_hs == m_k) m_wait = NP - 1;
        end
      end else if (!e_rd) begin
        m_wait--;
      end else if (res_ready) begin
        m_idx++;
        if (m_idx == NP) m_act = 0;
      end
    end
  end

  bit vpat1 [7] = '{1, 0, 1, 1, 0, 1, 1};
  bit rpat1 [4] = '{1, 0, 0, 1};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_feed_gate"}, feed_gate, 0);
    chk({tag, "_pe_en"}, pe_en, 0);
    chk({tag, "_pe_valid"}, pe_valid, 0);
    chk({tag, "_res_sel"}, res_sel, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_last"}, res_last, 0);
  endtask

  // vmode/rmode: 0 = always 1, 1 = fixed pattern, 2 = random.
  task automatic job(input int k, input int vmode, input int rmode, input bit spur,
                     input bit abort_drain, output int first_rv, output int ir,
                     output int bub, output int dsel);
    int n, si, ri;
    bit aborted;
    n = 0; si = 0; ri = 0; aborted = 0;
    first_rv = -1; ir = 0; bub = 0; dsel = -1;
    start = 1; cfg_len = LW'(k); in_valid = 0; res_ready = 0;
    cyc();
    start = 0;
    n = 1;
    while (n < 400) begin
      din = 8'($urandom);
      wt  = 8'($urandom);
      start   = spur && in_ready && (si == 2);
      cfg_len = start ? LW'(9) : LW'(k);
      in_valid  = (vmode == 0) ? 1'b1 : (vmode == 1) ? vpat1[si % 7] : ($urandom_range(0, 3) != 0);
      res_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? rpat1[ri % 4] : 1'($urandom_range(0, 1));
      #1;
      if (res_valid && first_rv < 0) first_rv = n;
      if (in_ready) begin
        ir++;
        if (!in_valid) bub++;
        si++;
      end
      if (res_valid) ri++;
      if (done) begin
        dsel = int'(res_sel);
        cyc();
        start = 0; in_valid = 0; res_ready = 0;
        break;
      end
      if (abort_drain && busy && !in_ready && !res_valid) begin
        rst_n = 0;
        aborted = 1;
        break;
      end
      cyc();
      n++;
    end
    start = 0;
    if (!aborted) chk("job_completes", (dsel >= 0), 1);
  endtask

  int frv, irc, bubc, dsl;

  initial begin
    #23;
    chk_reset_outs("reset");
    @(posedge clk); #1 rst_n = 1;
    cyc();

    // K=5, continuous input, always-ready consumer.
    job(5, 0, 0, 0, 0, frv, irc, bubc, dsl);
    chk("t1_in_ready_cycles", irc, 5);
    chk("t1_first_res_valid", frv, 9);
    chk("t1_done_sel", dsl, 3);

    // K=5 with two bubbles.
    job(5, 1, 0, 0, 0, frv, irc, bubc, dsl);
    chk("t2_handshakes", irc - bubc, 5);
    chk("t2_bubbles", bubc, 2);
    chk("t2_first_res_valid", frv, 11);

    // K=0 skips straight to readout.
    job(0, 0, 0, 0, 0, frv, irc, bubc, dsl);
    chk("t3_in_ready_cycles", irc, 0);
    chk("t3_first_res_valid", frv, 1);
    chk("t3_done_sel", dsl, 3);

    // Stalling consumer during readout.
    job(5, 0, 1, 0, 0, frv, irc, bubc, dsl);
    chk("t4_done_sel", dsl, 3);

    // start with cfg_len=9 mid-stream must be ignored.
    job(5, 0, 0, 1, 0, frv, irc, bubc, dsl);
    chk("t5_in_ready_cycles", irc, 5);
    chk("t5_first_res_valid", frv, 9);

    // Reset in DRAIN, then a clean K=3 job.
    job(5, 0, 0, 0, 1, frv, irc, bubc, dsl);
    #1;
    chk_reset_outs("abort");
    cyc();
    rst_n = 1;
    cyc();
    job(3, 0, 0, 0, 0, frv, irc, bubc, dsl);
    chk("t6_first_res_valid", frv, 7);
    chk("t6_done_sel", dsl, 3);

    for (int j = 0; j < 8; j++) begin
      job($urandom_range(0, 12), 2, 2, 1'($urandom_range(0, 1)), 0, frv, irc, bubc, dsl);
      chk("rand_done_sel", dsl, 3);
    end

    cyc();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/pe_chain_seq.md
# pe_chain_seq

Sequencer for a linear chain of complex-MAC processing elements, one accumulator per PE. It accepts a job (start + length) and gates the upstream sample/weight stream into the chain. After the last term it drains the weight pipeline, then hands the per-PE accumulators to a downstream consumer one index at a time. It sits between the sample/weight buffers and the PE chain's enable, valid and zero-gating controls. The result mux is external.

## Interface
Parameters:
- NUM_PE, 8: number of PEs in the chain (≥1)
- LEN_W, 10: width of the job length field
- SEL_W, $clog2(NUM_PE) (min 1): width of the result index

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  job request; sampled only in IDLE
- cfg_len  in  LEN_W  number of terms K, latched on an accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on the final result handshake
- in_valid  in  1  upstream sample/weight pair valid
- in_ready  out  1  controller accepts a pair
- feed_gate  out  1  1 = pass upstream pair into the chain; 0 = datapath forces din/w to zero
- pe_en  out  1  enable for all PEs; 0 clears the accumulators
- pe_valid  out  1  valid tag into PE0
- res_sel  out  SEL_W  PE index presented on the external result mux
- res_valid  out  1  result at res_sel is final
- res_ready  in  1  downstream accepts the result
- res_last  out  1  res_valid and res_sel == NUM_PE-1

## Operation
- States: IDLE, STREAM, DRAIN, READ.
- IDLE:
  - pe_en=0, so the accumulators are held clear.
  - start=1 → latch cfg_len, clear term_cnt, go to STREAM; if cfg_len==0, go directly to READ instead (all results zero).
- STREAM:
  - pe_en=1, in_ready=1; feed_gate = pe_valid = in_valid.
  - Each handshake (in_valid & in_ready) increments term_cnt.
  - A handshake with term_cnt == len-1 → go to DRAIN with drain_cnt = NUM_PE-1; if NUM_PE==1, go to READ.
  - in_valid=0 cycles insert zero terms (bubbles). Bit-exact correlation requires a stall-free burst; this is the upstream's responsibility.
- DRAIN:
  - pe_en=1, in_ready=0, feed_gate=0, pe_valid=0.
  - drain_cnt decrements each cycle; at 1 → READ.
- READ:
  - pe_en stays 1 with feed_gate=0. Zero terms hold the accumulators; pe_en=0 here would destroy the results.
  - res_valid=1, res_sel starts at 0.
  - res_valid & res_ready → res_sel+1; on res_last & res_ready → done=1 for that cycle, go to IDLE.
- start while busy is ignored; cfg_len is not re-latched.
- Accumulator width is the chain's concern; the controller does no arithmetic beyond its counters.

## Timing
- Reset values: state=IDLE, busy=0, done=0, in_ready=0, feed_gate=0, pe_en=0, pe_valid=0, res_sel=0, res_valid=0, res_last=0, all counters 0.
- pe_en, busy, in_ready, res_valid, res_sel and res_last decode from registers only.
- feed_gate and pe_valid combinationally follow in_valid during STREAM, so the datapath zero-mux and the pair arrive in the same cycle.
- A start accepted at edge S puts in_ready=1 in cycle S+1.
- A last term accepted at edge E puts res_valid=1 in cycle E+NUM_PE; PE i's final update happens at edge E+i.
- Zero-stall job latency from start to the first res_valid is K+NUM_PE cycles.
- Readout needs NUM_PE handshakes; res_sel holds while res_ready=0.
- done is asserted in the same cycle as the last handshake; busy=0 from the next cycle.
- A new start is accepted in the cycle after done, giving ≥1 IDLE cycle with pe_en=0 to clear the accumulators.
- rst_n asserted mid-job forces immediate IDLE with reset values; the partial job is discarded and in-flight pairs are dropped.

## Structure
- Shared package pe_pkg holds the state enum (IDLE/STREAM/DRAIN/READ) and the default NUM_PE/LEN_W localparams, shared with the chain top level.
- No sub-module: one FSM plus three counters (term, drain, result index). The PE chain and result mux are instantiated by the parent.

## Test plan
- NUM_PE=4, K=5, continuous in_valid, res_ready=1 → in_ready high for 5 cycles, res_valid 9 cycles after start, res_sel 0,1,2,3, done pulses with res_sel=3.
- K=5, in_valid pattern 1,0,1,1,0,1,1 → exactly 5 handshakes, feed_gate low on the 2 bubble cycles, pe_en never drops.
- K=0 → STREAM skipped, 4 results read out, all accumulators 0, done after 4 handshakes.
- res_ready toggling 1,0,0,1 in READ → res_sel holds, pe_en=1 throughout, accumulators unchanged.
- start pulsed during STREAM with cfg_len=9 → ignored, original K=5 completes.
- rst_n low in DRAIN → all outputs at reset values immediately; a following job with K=3 produces correct sums.
